// File: rtl/simple_mem_responder.sv
// simple_mem_responder
//   Memory-side responder for the simple memory access interface.
//   Single-beat writes and reads, a read-return pipeline of RD_LATENCY
//   cycles with an rvalid strobe, detection of illegal accesses (write and
//   read requested together) and saturating access counters.
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset
//   i_addr      word address of the access
//   i_wr_en     write request (one cycle per beat)
//   i_rd_en     read request (one cycle per beat)
//   i_wdata     write data, sampled with i_wr_en
//   o_rdata     read data, valid with o_rvalid, holds last value otherwise
//   o_rvalid    one-cycle strobe per completed read
//   o_err       one-cycle strobe after an illegal access
//   o_wr_count  accepted writes, saturating
//   o_rd_count  accepted reads, saturating
module simple_mem_responder #(
  parameter int unsigned       ADDR_W     = 2,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_wr_count,
  output logic [CNT_W-1:0]  o_rd_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("simple_mem_responder: RD_LATENCY must be within 1..4");
    end
  endgenerate

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [DATA_W-1:0]     r_pipe_data [RD_LATENCY];
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_rvalid;
  logic                  r_err;
  logic [CNT_W-1:0]      r_wr_count;
  logic [CNT_W-1:0]      r_rd_count;

  logic w_wr_acc;
  logic w_rd_acc;
  logic w_illegal;

  // A beat with both enables high is rejected entirely.
  assign w_wr_acc  = i_wr_en & ~i_rd_en;
  assign w_rd_acc  = i_rd_en & ~i_wr_en;
  assign w_illegal = i_wr_en & i_rd_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_data[i] <= '0;
      r_pipe_vld <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (w_wr_acc) begin
        r_mem[i_addr] <= i_wdata;
        if (r_wr_count != '1) r_wr_count <= r_wr_count + CNT_W'(1);
      end

      // Stage 0 captures the array contents at the accept edge; write and
      // read are exclusive, so no bypass path is needed.
      r_pipe_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_pipe_data[0] <= r_mem[i_addr];
        if (r_rd_count != '1) r_rd_count <= r_rd_count + CNT_W'(1);
      end

      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end

      // The output register adds the final cycle, so a read accepted at
      // edge N is presented after edge N+RD_LATENCY.
      r_rvalid <= r_pipe_vld[RD_LATENCY-1];
      if (r_pipe_vld[RD_LATENCY-1]) r_rdata <= r_pipe_data[RD_LATENCY-1];

      r_err <= w_illegal;
    end
  end

  assign o_rdata    = r_rdata;
  assign o_rvalid   = r_rvalid;
  assign o_err      = r_err;
  assign o_wr_count = r_wr_count;
  assign o_rd_count = r_rd_count;

endmodule

// File: tb/tb_simple_mem_responder.sv
// Directed bench for simple_mem_responder. Three instances share one
// stimulus stream: latency 1 (defaults), latency 2 with a non-zero reset
// value, latency 3 with 4-bit counters.
module tb_simple_mem_responder;

  logic       clk;
  logic       rst;
  logic [1:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;

  logic [7:0]  o1_rdata, o2_rdata, o3_rdata;
  logic        o1_rvalid, o2_rvalid, o3_rvalid;
  logic        o1_err, o2_err, o3_err;
  logic [15:0] o1_wr_count, o1_rd_count, o2_wr_count, o2_rd_count;
  logic [3:0]  o3_wr_count, o3_rd_count;

  int n_cmp = 0;
  int n_err = 0;

  simple_mem_responder #(.RD_LATENCY(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_wdata(wdata), .o_rdata(o1_rdata), .o_rvalid(o1_rvalid), .o_err(o1_err),
    .o_wr_count(o1_wr_count), .o_rd_count(o1_rd_count));

  simple_mem_responder #(.RD_LATENCY(2), .RESET_VAL(8'h3C)) u_lat2 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_wdata(wdata), .o_rdata(o2_rdata), .o_rvalid(o2_rvalid), .o_err(o2_err),
    .o_wr_count(o2_wr_count), .o_rd_count(o2_rd_count));

  simple_mem_responder #(.RD_LATENCY(3), .CNT_W(4)) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_wdata(wdata), .o_rdata(o3_rdata), .o_rvalid(o3_rvalid), .o_err(o3_err),
    .o_wr_count(o3_wr_count), .o_rd_count(o3_rd_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    addr  = a;
    wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_d [4] = '{8'h44, 8'h22, 8'h11, 8'h33};
  logic [1:0] rd_order [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
  logic [7:0] wr_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst = 1'b1;
    drive(0, 0, 2'd0, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rdata",    16'(o1_rdata),    16'h0);
    chk("rst_rvalid",   16'(o1_rvalid),   16'h0);
    chk("rst_err",      16'(o1_err),      16'h0);
    chk("rst_wr_count", 16'(o1_wr_count), 16'h0);
    chk("rst_rd_count", 16'(o1_rd_count), 16'h0);
    chk("rst_rdata_l2", 16'(o2_rdata),    16'h0);

    // Back-to-back reads of addr 0..3 after reset.
    drive(0, 1, 2'd0, 8'h00);
    tick();
    chk("b2b_first_edge_rvalid", 16'(o1_rvalid), 16'h0);
    for (int a = 1; a < 4; a++) begin
      drive(0, 1, 2'(a), 8'h00);
      tick();
      chk("b2b_rvalid", 16'(o1_rvalid), 16'h1);
      chk("b2b_rdata",  16'(o1_rdata),  16'h0);
    end
    drive(0, 0, 2'd0, 8'h00);
    tick();
    chk("b2b_last_rvalid", 16'(o1_rvalid), 16'h1);
    chk("b2b_l2_rvalid",   16'(o2_rvalid), 16'h1);
    chk("b2b_l2_rdata",    16'(o2_rdata),  16'h3C);
    chk("b2b_l3_rvalid",   16'(o3_rvalid), 16'h1);
    tick();
    chk("b2b_drain_rvalid", 16'(o1_rvalid),   16'h0);
    chk("b2b_rd_count",     16'(o1_rd_count), 16'h4);
    chk("b2b_wr_count",     16'(o1_wr_count), 16'h0);
    chk("b2b_l3_rd_count",  16'(o3_rd_count), 16'h4);

    // Write then read same address on the following edge.
    drive(1, 0, 2'd2, 8'hA5);
    tick();
    drive(0, 1, 2'd2, 8'h00);
    tick();
    chk("raw_accept_rvalid", 16'(o1_rvalid), 16'h0);
    drive(0, 0, 2'd0, 8'h00);
    tick();
    chk("raw_rvalid",   16'(o1_rvalid),   16'h1);
    chk("raw_rdata",    16'(o1_rdata),    16'hA5);
    chk("raw_wr_count", 16'(o1_wr_count), 16'h1);
    chk("raw_rd_count", 16'(o1_rd_count), 16'h5);
    tick();
    chk("raw_rvalid_drop", 16'(o1_rvalid), 16'h0);
    chk("raw_rdata_hold",  16'(o1_rdata),  16'hA5);
    chk("raw_l2_rvalid",   16'(o2_rvalid), 16'h1);
    chk("raw_l2_rdata",    16'(o2_rdata),  16'hA5);
    tick();
    chk("raw_l2_rvalid_drop", 16'(o2_rvalid), 16'h0);
    chk("raw_l3_rvalid",      16'(o3_rvalid), 16'h1);
    chk("raw_l3_rdata",       16'(o3_rdata),  16'hA5);
    tick();
    chk("raw_l3_rvalid_drop", 16'(o3_rvalid), 16'h0);

    // Fill 0..3, then read 3,1,0,2 back-to-back; check all three latencies.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 2'(i), wr_vals[i]);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(0, 1, rd_order[k], 8'h00);
      else       drive(0, 0, 2'd0, 8'h00);
      tick();
      chk("seq_l1_rvalid", 16'(o1_rvalid), 16'((k >= 1 && k <= 4) ? 1 : 0));
      if (k >= 1 && k <= 4) chk("seq_l1_rdata", 16'(o1_rdata), 16'(exp_d[k-1]));
      chk("seq_l2_rvalid", 16'(o2_rvalid), 16'((k >= 2 && k <= 5) ? 1 : 0));
      if (k >= 2 && k <= 5) chk("seq_l2_rdata", 16'(o2_rdata), 16'(exp_d[k-2]));
      chk("seq_l3_rvalid", 16'(o3_rvalid), 16'((k >= 3 && k <= 6) ? 1 : 0));
      if (k >= 3 && k <= 6) chk("seq_l3_rdata", 16'(o3_rdata), 16'(exp_d[k-3]));
    end
    chk("seq_wr_count", 16'(o1_wr_count), 16'h5);
    chk("seq_rd_count", 16'(o1_rd_count), 16'h9);

    // Illegal access leaves memory and counters alone.
    drive(1, 0, 2'd1, 8'h5A);
    tick();
    chk("ill_pre_err", 16'(o1_err), 16'h0);
    drive(1, 1, 2'd1, 8'hFF);
    tick();
    chk("ill_err_l1",   16'(o1_err),      16'h1);
    chk("ill_err_l3",   16'(o3_err),      16'h1);
    chk("ill_rvalid",   16'(o1_rvalid),   16'h0);
    chk("ill_wr_count", 16'(o1_wr_count), 16'h6);
    chk("ill_rd_count", 16'(o1_rd_count), 16'h9);
    drive(0, 1, 2'd1, 8'h00);
    tick();
    chk("ill_err_clear", 16'(o1_err),      16'h0);
    chk("ill_rd_count2", 16'(o1_rd_count), 16'hA);
    drive(0, 0, 2'd0, 8'h00);
    tick();
    chk("ill_read_rvalid", 16'(o1_rvalid), 16'h1);
    chk("ill_read_rdata",  16'(o1_rdata),  16'h5A);
    tick();
    chk("ill_read_l2_rdata", 16'(o2_rdata), 16'h5A);
    tick();
    chk("ill_read_l3_rdata", 16'(o3_rdata), 16'h5A);
    tick();

    // Reset the edge after a read: the in-flight read must vanish.
    drive(0, 1, 2'd0, 8'h00);
    tick();
    rst = 1'b1;
    drive(0, 0, 2'd0, 8'h00);
    tick();
    rst = 1'b0;
    chk("rst_mid_rvalid_l1", 16'(o1_rvalid),   16'h0);
    chk("rst_mid_rvalid_l2", 16'(o2_rvalid),   16'h0);
    chk("rst_mid_rdata_l2",  16'(o2_rdata),    16'h0);
    chk("rst_mid_wr_count",  16'(o2_wr_count), 16'h0);
    chk("rst_mid_rd_count",  16'(o2_rd_count), 16'h0);
    chk("rst_mid_l3_wr",     16'(o3_wr_count), 16'h0);
    drive(0, 1, 2'd1, 8'h00);
    tick();
    chk("rst_mid_flush_l2", 16'(o2_rvalid), 16'h0);
    drive(0, 0, 2'd0, 8'h00);
    tick();
    chk("rst_mid_flush_l3",  16'(o3_rvalid), 16'h0);
    chk("rst_mem_l1_rvalid", 16'(o1_rvalid), 16'h1);
    chk("rst_mem_l1_rdata",  16'(o1_rdata),  16'h00);
    tick();
    chk("rst_mem_l2_rvalid", 16'(o2_rvalid), 16'h1);
    chk("rst_mem_l2_rdata",  16'(o2_rdata),  16'h3C);
    tick();
    chk("rst_mem_l3_rvalid", 16'(o3_rvalid), 16'h1);
    chk("rst_mem_l3_rdata",  16'(o3_rdata),  16'h00);

    // 17 writes: the 4-bit counter saturates at 15.
    for (int i = 1; i <= 17; i++) begin
      drive(1, 0, 2'(i), 8'(i));
      tick();
      if (i >= 14) chk("sat_l3_wr_count", 16'(o3_wr_count), 16'((i < 15) ? i : 15));
    end
    chk("sat_l1_wr_count", 16'(o1_wr_count), 16'd17);
    chk("sat_l3_rd_count", 16'(o3_rd_count), 16'd1);
    drive(0, 0, 2'd0, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/simple_mem_responder.md
Name: simple_mem_responder

Overview:
- Responder (memory end) of the team's simple memory access interface: accepts single-beat writes and reads driven by the bench driver on addr/wr_en/rd_en/wdata, and returns read data on rdata.
- Adds a configurable read-latency pipeline, a read-valid strobe, illegal-access detection and saturating access counters.
- Serves as the DUT behind the DRIVER/MONITOR modports; the monitor samples rdata/rvalid.

Parameters:
- ADDR_W, 2, address width; depth = 2**ADDR_W entries.
- DATA_W, 8, data width of wdata/rdata.
- RD_LATENCY, 1, cycles from read-accept edge to rvalid; legal range 1..4, other values are a elaboration error.
- RESET_VAL, 0, value loaded into every memory entry on reset.
- CNT_W, 16, width of access counters.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  word address of the access.
- wr_en  input  1  write request, single cycle per beat.
- rd_en  input  1  read request, single cycle per beat.
- wdata  input  DATA_W  write data, sampled with wr_en.
- rdata  output  DATA_W  read data; valid when rvalid=1, holds last returned value otherwise.
- rvalid  output  1  one-cycle strobe per completed read.
- err  output  1  one-cycle strobe: illegal access (wr_en and rd_en both high) seen on previous edge.
- wr_count  output  CNT_W  number of accepted writes, saturating.
- rd_count  output  CNT_W  number of accepted reads, saturating.

Behaviour:
- Reset (rst=1 at a rising edge): all entries <= RESET_VAL; rdata=0, rvalid=0, err=0, wr_count=0, rd_count=0; read pipeline flushed. Requests at that edge are ignored. Reset mid-read: in-flight reads are dropped, with no rvalid after reset deassertion.
- Write accept: wr_en=1, rd_en=0 at an edge -> mem[addr] <= wdata at that edge; wr_count += 1 unless at all-ones.
- Read accept: rd_en=1, wr_en=0 at an edge -> mem[addr] captured at that edge into pipeline stage 0; rd_count += 1 unless at all-ones.
- Read return: rvalid=1 and rdata=captured value exactly RD_LATENCY cycles after the accept edge (RD_LATENCY=1: visible after the next edge).
- rvalid deasserts the following cycle unless another read is due; rdata is not cleared.
- Throughput: one request per cycle; back-to-back reads produce back-to-back rvalid in issue order; no backpressure.
- Read-after-write: a read accepted on the edge after a write to the same address returns the new data. Mixed read/write streams return data in program order.
- Illegal access: wr_en=1 and rd_en=1 at the same edge -> no write, no read, counters unchanged; err=1 for the following cycle only. The pipeline continues draining earlier reads.
- Idle (both low): no state change except pipeline advance; err=0.
- Address is full-width, so there is no out-of-range case; addr wraps naturally at 2**ADDR_W.
- Counter saturation: at 2**CNT_W-1 the counter holds; it does not wrap.
- Inputs are sampled only at rising edges; the driver's output skew is irrelevant to the responder.

Test Plan:
- Reset then read addr 0..3 back-to-back (RESET_VAL=0, RD_LATENCY=1) -> four consecutive rvalid pulses, rdata=0x00 each; rd_count=4, wr_count=0.
- Write 0xA5 to addr 2, then read addr 2 on the next cycle -> rvalid one cycle after the read edge with rdata=0xA5; wr_count=1, rd_count=1.
- RD_LATENCY=3: write 0x11,0x22,0x33,0x44 to addr 0..3, read 3,1,0,2 back-to-back -> rvalid for 4 cycles starting 3 cycles after the first read edge; rdata sequence 0x44,0x22,0x11,0x33.
- Drive wr_en=1, rd_en=1, addr=1, wdata=0xFF when mem[1]=0x5A -> err pulses for one cycle; then read addr 1 returns 0x5A; counters unchanged by the illegal beat.
- RD_LATENCY=2: issue read, assert rst on the next edge -> no rvalid ever appears; rdata=0, counters=0, mem[*]=RESET_VAL afterwards.
- CNT_W=4: 17 writes -> wr_count reaches 15 and holds at 15.
